// File: rtl/mux_gate_arbiter_if.sv
// Handshake bundle for mux_gate_arbiter: per-requester request channel plus
// a single tagged response channel. master = requesters/downstream side,
// slave = the arbiter.
interface mux_gate_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0][1:0] req_op;     // requester k owns bits [2k+1:2k]
  logic [NUM_REQ-1:0]      req_a;
  logic [NUM_REQ-1:0]      req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_data;
  logic                    rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/mux_gate_arbiter.sv
// mux_gate_arbiter: round-robin arbiter sharing one 2:1-mux-built logic unit
// among NUM_REQ requesters. IDLE grants, EVAL computes, RESP returns result.
// Optional feature macro: MUX_GATE_XOR_EN (opcode 11 = a XOR b; otherwise
// opcode 11 is illegal and returns data=0, err=1).
module mux_gate_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_gate_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic            a;
    logic            b;
    logic [ID_W-1:0] id;
  } req_t;

  state_t             state, state_d;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    scan_id;
  int                 scan;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               found;
  req_t               cap;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_data_q;
  logic               rsp_err_q;

  // The only logic primitive of the shared unit.
  function automatic logic mux2(input logic sel, input logic [1:0] i);
    return sel ? i[1] : i[0];
  endfunction

  // Shared unit: one mux tree fed by the captured request, selected by op.
  logic y_and, y_or, y_not, y_hi, y_lo, y_out, y_err;
  assign y_and = mux2(cap.a, {cap.b, 1'b0});
  assign y_or  = mux2(cap.a, {1'b1, cap.b});
  assign y_not = mux2(cap.a, 2'b01);
`ifdef MUX_GATE_XOR_EN
  logic n_b, y_xor;
  assign n_b   = mux2(cap.b, 2'b01);
  assign y_xor = mux2(cap.a, {n_b, cap.b});
  assign y_hi  = mux2(cap.op[0], {y_xor, y_not});
  assign y_err = 1'b0;
`else
  assign y_hi  = mux2(cap.op[0], {1'b0, y_not});
  assign y_err = cap.op[1] & cap.op[0];
`endif
  assign y_lo  = mux2(cap.op[0], {y_or, y_and});
  assign y_out = mux2(cap.op[1], {y_hi, y_lo});

  // Round-robin search from ptr upward, wrapping at NUM_REQ.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = 0;
    scan_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = int'(ptr) + i;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_id = ID_W'(scan);
      if (!found && bus.req_valid[scan_id]) begin
        found          = 1'b1;
        grant[scan_id] = 1'b1;
        gnt_idx        = scan_id;
      end
    end
  end

  // FSM next state; ready is the grant only while idle.
  always_comb begin
    state_d     = state;
    req_ready_c = '0;
    case (state)
      IDLE: begin
        req_ready_c = grant;
        if (found) state_d = EVAL;
      end
      EVAL:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Capture on grant, register result in EVAL, advance ptr on response accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap        <= '0;
      ptr        <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        cap.op <= bus.req_op[gnt_idx];
        cap.a  <= bus.req_a[gnt_idx];
        cap.b  <= bus.req_b[gnt_idx];
        cap.id <= gnt_idx;
      end
      if (state == EVAL) begin
        rsp_id_q   <= cap.id;
        rsp_data_q <= y_out;
        rsp_err_q  <= y_err;
      end
      if (state == RESP && bus.rsp_ready)
        ptr <= (cap.id == ID_W'(NUM_REQ - 1)) ? '0 : cap.id + 1'b1;
    end
  end

  // Ready is forced low while reset is asserted, even with requests pending.
  assign bus.req_ready = rst_n ? req_ready_c : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
